// File: rtl/uart_pkg.sv
// Shared types and constants for the UART instruction receiver.
// Optional parity support is selected with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned BYTES_PER_WORD   = 4;
  localparam int unsigned CLKS_PER_BIT_DEF = 434;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// UART bit receiver: synchronizer, start/data/stop sampling, byte out.
// With UART_RX_PARITY_EN an even-parity bit precedes the stop bit.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          rx_s;

  assign rx_s   = sync_q[1];
  assign byte_o = shift_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        par_d = 1'b0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = RX_PARITY;
`else
          if (bit_q == 3'd7) state_d = RX_STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          par_d   = rx_s ^ (^shift_q);
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          // a parity mismatch is only reported here, as a framing error
          if (rx_s && !par_q) byte_valid_o = 1'b1;
          else                frame_err_o  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_instr_rx.sv
// Assembles received UART bytes into little-endian 32-bit words.
// Build with UART_RX_PARITY_EN to expect an even-parity bit per byte.
module uart_instr_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  output logic [1:0]  o_byte_idx,
  output logic        o_frame_err
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] stage_q, stage_d;
  logic [31:0] word_q, word_d;
  logic        wvalid_q, wvalid_d;
  logic        ferr_q, ferr_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (i_rx),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      stage_q  <= '0;
      word_q   <= '0;
      wvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      stage_q  <= stage_d;
      word_q   <= word_d;
      wvalid_q <= wvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    idx_d    = idx_q;
    stage_d  = stage_q;
    word_d   = word_q;
    wvalid_d = 1'b0;
    ferr_d   = 1'b0;
    if (rx_valid) begin
      stage_d[idx_q*8 +: 8] = rx_byte;
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        word_d   = {rx_byte, stage_q[23:0]};
        wvalid_d = 1'b1;
      end
    end else if (rx_err) begin
      // staged bytes are left in place; they get overwritten before reuse
      idx_d  = '0;
      ferr_d = 1'b1;
    end
  end

  assign o_word_valid = wvalid_q;
  assign o_word       = word_q;
  assign o_byte_idx   = idx_q;
  assign o_frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_instr_rx.sv
// Directed bench for uart_instr_rx at 16 clocks per bit.
module tb_uart_instr_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_rx = 1'b1;
  logic        o_word_valid;
  logic [31:0] o_word;
  logic [1:0]  o_byte_idx;
  logic        o_frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both = 0;
  int vt [64];

  uart_instr_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (i_rx),
    .o_word_valid(o_word_valid),
    .o_word      (o_word),
    .o_byte_idx  (o_byte_idx),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (o_word_valid) begin
      if (vcnt < 64) vt[vcnt] = cyc;
      vcnt++;
    end
    if (o_frame_err) ecnt++;
    if (o_word_valid && o_frame_err) both++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bitw(input logic b);
    i_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    bitw(1'b0);
    for (int i = 0; i < 8; i++) bitw(d[i]);
`ifdef UART_RX_PARITY_EN
    bitw(^d);
`endif
    bitw(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] d, input logic p);
    bitw(1'b0);
    for (int i = 0; i < 8; i++) bitw(d[i]);
    bitw(p);
    bitw(1'b1);
  endtask
`endif

  initial begin
    int v0;
    int e0;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    check("rst_word", o_word, 32'h0);
    check("rst_idx", 32'(o_byte_idx), 32'd0);
    check("rst_valid", 32'(o_word_valid), 32'd0);
    check("rst_ferr", 32'(o_frame_err), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    v0 = vcnt;
    e0 = ecnt;
    send_byte(8'h13, 1'b1);
    check("idx_after_b0", 32'(o_byte_idx), 32'd1);
    send_byte(8'h05, 1'b1);
    check("idx_after_b1", 32'(o_byte_idx), 32'd2);
    send_byte(8'h10, 1'b1);
    check("idx_after_b2", 32'(o_byte_idx), 32'd3);
    check("no_early_valid", 32'(vcnt - v0), 32'd0);
    send_byte(8'h00, 1'b1);
    check("idx_wrap", 32'(o_byte_idx), 32'd0);
    check("word_addi", o_word, 32'h00100513);
    check("valid_single", 32'(vcnt - v0), 32'd1);
    check("no_err_word1", 32'(ecnt - e0), 32'd0);

    v0 = vcnt;
    e0 = ecnt;
    i_rx = 1'b0;
    repeat (4) @(negedge clk);
    i_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_idx", 32'(o_byte_idx), 32'd0);
    check("glitch_noerr", 32'(ecnt - e0), 32'd0);
    check("glitch_novalid", 32'(vcnt - v0), 32'd0);

    v0 = vcnt;
    e0 = ecnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    i_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("ferr_pulse", 32'(ecnt - e0), 32'd1);
    check("ferr_idx", 32'(o_byte_idx), 32'd0);
    check("ferr_word_held", o_word, 32'h00100513);
    check("ferr_novalid", 32'(vcnt - v0), 32'd0);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    check("word_deadbeef", o_word, 32'hDEADBEEF);
    check("valid_after_err", 32'(vcnt - v0), 32'd1);
    check("single_err", 32'(ecnt - e0), 32'd1);

    e0 = ecnt;
    v0 = vcnt;
    send_byte(8'h55, 1'b1);
    d = 8'hAA;
    bitw(1'b0);
    for (int i = 0; i < 4; i++) bitw(d[i]);
    i_rx = d[4];
    repeat (8) @(negedge clk);
    rst = 1'b0;
    i_rx = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_idx", 32'(o_byte_idx), 32'd0);
    check("midrst_word", o_word, 32'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("word_addi_x1", o_word, 32'h00000093);
    check("midrst_noerr", 32'(ecnt - e0), 32'd0);
    check("midrst_valid", 32'(vcnt - v0), 32'd1);

    v0 = vcnt;
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 4; b++) send_byte(8'(w * 4 + b + 1), 1'b1);
    end
    check("burst_count", 32'(vcnt - v0), 32'd8);
    for (int i = 1; i < 8; i++) begin
      check("burst_spacing", 32'(vt[v0 + i] - vt[v0 + i - 1]),
            32'(FBITS * CPB * 4));
    end
    check("burst_last_word", o_word, 32'h201F1E1D);

`ifdef UART_RX_PARITY_EN
    e0 = ecnt;
    send_par(8'hA5, 1'b1);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("par_err", 32'(ecnt - e0), 32'd1);
    check("par_err_idx", 32'(o_byte_idx), 32'd0);
    send_par(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    check("par_ok_idx", 32'(o_byte_idx), 32'd1);
    check("par_ok_noerr", 32'(ecnt - e0), 32'd1);
`endif

    check("valid_err_exclusive", 32'(both), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_instr_rx.md
UART_INSTR_RX -- requirements
Module: uart_instr_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200 baud); legal range 16..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_rx  input  1  asynchronous UART serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-005 SHALL have port o_word_valid  output  1  one-cycle pulse when a full 32-bit word has been assembled.
REQ-006 SHALL have port o_word  output  32  assembled word, held stable until the next word completes.
REQ-007 SHALL have port o_byte_idx  output  2  number of bytes of the current word received so far (0..3).
REQ-008 SHALL have port o_frame_err  output  1  one-cycle pulse on stop-bit (or parity) error.

Function
REQ-009 i_rx SHALL pass through a two-flop synchronizer (reset value 1) before any use.
REQ-010 Bit receiver FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY per REQ-024), with a baud counter of width clog2(CLKS_PER_BIT).
REQ-011 IDLE->START on synchronized rx = 0; START samples at CLKS_PER_BIT/2 (integer division): low -> DATA, high -> IDLE (glitch rejected, nothing reported).
REQ-012 DATA SHALL sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, shifting LSB first; after bit 7 -> STOP.
REQ-013 STOP samples CLKS_PER_BIT cycles after bit 7: high -> byte accepted; low -> o_frame_err pulse, byte discarded, o_byte_idx cleared to 0; both cases -> IDLE.
REQ-014 Accepted byte number k (k = o_byte_idx before acceptance) SHALL be written to word bits [8k+7:8k] (first byte = bits [7:0], little-endian).
REQ-015 On acceptance of byte k=3, the full word SHALL appear on o_word and o_word_valid SHALL pulse high for exactly one cycle, in the cycle after the stop-bit sample; o_byte_idx wraps to 0.
REQ-016 o_word SHALL NOT change except on a word completion; partial bytes go to an internal staging register.
REQ-017 A new start bit SHALL be accepted in the cycle after STOP (back-to-back bytes, no idle gap required).
REQ-018 A framing error SHALL discard all staged bytes of the current word; staging register is not cleared but is fully overwritten before the next completion.
REQ-019 o_word_valid and o_frame_err SHALL never be high in the same cycle.

Reset
REQ-020 On rst low: FSM = IDLE, synchronizer = 2'b11, baud counter = 0, o_byte_idx = 0, o_word = 0, staging = 0, o_word_valid = 0, o_frame_err = 0.
REQ-021 Reset asserted mid-byte or mid-word SHALL abandon it; after release the next falling edge on i_rx starts byte 0 of a fresh word.

Configuration
REQ-022 Macro UART_RX_PARITY_EN SHALL select parity support.
REQ-023 Without UART_RX_PARITY_EN: frame is start, 8 data, stop; no PARITY state exists.
REQ-024 With UART_RX_PARITY_EN: an even-parity bit follows bit 7 and is sampled in state PARITY, CLKS_PER_BIT after bit 7; STOP is sampled CLKS_PER_BIT later; a parity mismatch is treated exactly like a framing error (REQ-013), reported once at the stop sample.

Structure
REQ-025 Shared package uart_pkg SHALL hold the rx FSM state encoding, BYTES_PER_WORD = 4 and the default CLKS_PER_BIT.
REQ-026 Bit-level receiving (REQ-009..013, REQ-024) SHALL be sub-module uart_rx_byte (outputs: byte, byte_valid pulse, frame_err pulse); uart_instr_rx instantiates it and performs word assembly.

Verification (CLKS_PER_BIT = 16 unless stated)
REQ-027 Bytes 0x13, 0x05, 0x10, 0x00 back-to-back -> o_word = 0x00100513, o_word_valid single pulse 1 cycle after the 4th stop sample, o_byte_idx 0->1->2->3->0.
REQ-028 i_rx low for 4 cycles then high -> no byte, no error, o_byte_idx stays 0.
REQ-029 Byte 2 sent with stop bit 0 -> o_frame_err pulse, o_byte_idx = 0, o_word unchanged; then 0xEF, 0xBE, 0xAD, 0xDE -> o_word = 0xDEADBEEF.
REQ-030 rst low during bit 4 of byte 1, then full word 0x00000093 -> o_word = 0x00000093, no o_frame_err.
REQ-031 Eight consecutive words with 0-cycle inter-frame gaps -> eight o_word_valid pulses, each exactly 10 x CLKS_PER_BIT cycles x 4 bytes apart.
REQ-032 With UART_RX_PARITY_EN, byte 0xA5 with parity bit 1 -> o_frame_err pulse, o_byte_idx = 0; with parity bit 0 -> accepted.
